// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32I pipeline sequencing controller: FSM state
// encoding, the flush NOP, opcode constants and the load-use hazard test.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } hz_state_e;

  // addi x0, x0, 0 -- written into a stage register when it is flushed
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;

  // x0 never carries a dependency, so a load targeting it cannot hazard
  function automatic logic load_use_hit(input logic [4:0] rs1,
                                        input logic [4:0] rs2,
                                        input logic       uses_rs1,
                                        input logic       uses_rs2,
                                        input logic [4:0] rd,
                                        input logic       mem_read);
    return mem_read && (rd != 5'd0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, EX redirect flush,
// memory-wait freeze with timeout watchdog, and saturating event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             fault,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       state
);

  // Handshake: the MEM access completes in the cycle where mem_req and
  // mem_ack are both high; mem_ack alone carries no meaning.

  localparam logic [CNT_W:0] TIMEOUT = (CNT_W+1)'(MEM_TIMEOUT);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             fault_q, fault_d;
  logic [CNT_W:0]   wait_inc;
  logic [CNT_W-1:0] wait_base;
  logic             load_use;
  logic             hold;
  logic             stall_inc;
  logic             flush_inc;

  assign load_use = load_use_hit(id_rs1_addr, id_rs2_addr, id_uses_rs1,
                                 id_uses_rs2, ex_rd_addr, ex_mem_read);

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    hold         = 1'b0;
    wait_base    = '0;
    wait_inc     = '0;
    state_d      = state_q;
    wait_d       = wait_q;
    fault_d      = fault_q;

    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      state_d      = RUN;
      wait_d       = '0;
      fault_d      = 1'b0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (state_q == MEM_WAIT) begin
            hold      = !(mem_req && mem_ack);
            wait_base = wait_q;
          end else begin
            hold      = mem_req && !mem_ack;
          end

          if (hold) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            stall_inc    = 1'b1;
            // The first frozen cycle (still in RUN) counts toward the timeout
            wait_inc     = {1'b0, wait_base} + (CNT_W+1)'(1);
            if (wait_inc >= TIMEOUT) begin
              state_d = FAULT;
              wait_d  = '0;
              fault_d = 1'b1;
            end else begin
              state_d = MEM_WAIT;
              wait_d  = wait_inc[CNT_W-1:0];
            end
          end else begin
            state_d = RUN;
            wait_d  = '0;
            // A redirect wins over load-use: the ID instruction is wrong-path
            if (ex_redirect) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              flush_inc  = 1'b1;
            end else if (load_use) begin
              pc_write   = 1'b0;
              ifid_write = 1'b0;
              idex_flush = 1'b1;
              stall_inc  = 1'b1;
            end
          end
        end

        FAULT: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
          fault_d      = 1'b1;
        end

        default: begin
          state_d = RUN;
          wait_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    wait_q  <= wait_d;
    fault_q <= fault_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .inc   (stall_inc),
    .clr   (reset),
    .value (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .inc   (flush_inc),
    .clr   (reset),
    .value (flush_count)
  );

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of single-cycle vectors plus
// hand-written memory-wait, timeout, saturation and reset sequences.
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TMO     = 4;
  localparam int CNT_MAX = 15;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MW  = 2'd1;
  localparam logic [1:0] S_FLT = 2'd2;

  // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [6:0] C_NORM  = 7'b1111_000;
  localparam logic [6:0] C_LU    = 7'b0011_010;
  localparam logic [6:0] C_REDIR = 7'b1111_110;
  localparam logic [6:0] C_FRZ   = 7'b0000_001;
  localparam logic [6:0] C_RST   = 7'b0000_111;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       req;
    logic       ack;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] ctrl;
    logic       s_inc;
    logic       f_inc;
    logic [1:0] st;
    logic       flt;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic             id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic             mem_req, mem_ack;
  logic             pc_write, ifid_write, idex_write, exmem_write;
  logic             ifid_flush, idex_flush, memwb_bubble, fault;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [1:0]       state;

  int checks = 0;
  int passes = 0;
  int m_stall = 0;
  int m_flush = 0;
  logic [6:0] exp_q[$];
  vec_t tbl[10];

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_rd_addr   (ex_rd_addr),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .exmem_write  (exmem_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_bubble (memwb_bubble),
    .fault        (fault),
    .stall_count  (stall_count),
    .flush_count  (flush_count),
    .state        (state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic in_t mk_in(logic rst, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic [4:0] rd, logic mr,
                                logic redir, logic req, logic ack);
    in_t r;
    r.rst = rst; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
    r.rd = rd; r.mr = mr; r.redir = redir; r.req = req; r.ack = ack;
    return r;
  endfunction

  function automatic vec_t mk_vec(in_t in, logic [6:0] ctrl, logic s_inc,
                                  logic f_inc, logic [1:0] st, logic flt);
    vec_t v;
    v.in = in; v.ctrl = ctrl; v.s_inc = s_inc; v.f_inc = f_inc;
    v.st = st; v.flt = flt;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input in_t i);
    reset       = i.rst;
    id_rs1_addr = i.rs1;
    id_rs2_addr = i.rs2;
    id_uses_rs1 = i.u1;
    id_uses_rs2 = i.u2;
    ex_rd_addr  = i.rd;
    ex_mem_read = i.mr;
    ex_redirect = i.redir;
    mem_req     = i.req;
    mem_ack     = i.ack;
  endtask

  // Drive one cycle, compare combinational controls mid-cycle, then
  // compare registered state/fault/counters just after the edge.
  task automatic apply(input vec_t v, input int idx);
    logic [6:0] got;
    logic [6:0] want;
    drive(v.in);
    exp_q.push_back(v.ctrl);
    #3;
    got  = {pc_write, ifid_write, idex_write, exmem_write,
            ifid_flush, idex_flush, memwb_bubble};
    want = exp_q.pop_front();
    check("ctrl", idx, {1'b0, got}, {1'b0, want});
    if (v.in.rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (v.s_inc && m_stall < CNT_MAX) m_stall++;
      if (v.f_inc && m_flush < CNT_MAX) m_flush++;
    end
    @(posedge clk);
    #1;
    check("state", idx, {6'd0, state}, {6'd0, v.st});
    check("fault", idx, {7'd0, fault}, {7'd0, v.flt});
    check("stall_count", idx, {4'd0, stall_count}, 8'(m_stall));
    check("flush_count", idx, {4'd0, flush_count}, 8'(m_flush));
  endtask

  initial begin
    in_t idle, wait_in, ack_in, lu_in;
    int k;
    idle    = mk_in(0, 5'd1, 5'd2, 1, 1, 5'd9, 0, 0, 0, 0);
    wait_in = mk_in(0, 5'd1, 5'd2, 1, 1, 5'd9, 0, 0, 1, 0);
    drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;

    // reset held high
    apply(mk_vec(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), C_RST, 0, 0, S_RUN, 0), 0);
    apply(mk_vec(mk_in(1, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0), C_RST, 0, 0, S_RUN, 0), 1);

    // single-cycle RUN vectors
    tbl[0] = mk_vec(mk_in(0, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0, 0), C_NORM,  0, 0, S_RUN, 0);
    tbl[1] = mk_vec(mk_in(0, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0, 0), C_LU,    1, 0, S_RUN, 0);
    tbl[2] = mk_vec(mk_in(0, 5'd0, 5'd1, 1, 1, 5'd0, 1, 0, 0, 0), C_NORM,  0, 0, S_RUN, 0);
    tbl[3] = mk_vec(mk_in(0, 5'd3, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0), C_LU,    1, 0, S_RUN, 0);
    tbl[4] = mk_vec(mk_in(0, 5'd3, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0), C_NORM,  0, 0, S_RUN, 0);
    tbl[5] = mk_vec(mk_in(0, 5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0), C_NORM,  0, 0, S_RUN, 0);
    tbl[6] = mk_vec(mk_in(0, 5'd5, 5'd1, 1, 1, 5'd5, 1, 1, 0, 0), C_REDIR, 0, 1, S_RUN, 0);
    tbl[7] = mk_vec(mk_in(0, 5'd1, 5'd2, 1, 1, 5'd9, 0, 1, 0, 0), C_REDIR, 0, 1, S_RUN, 0);
    tbl[8] = mk_vec(mk_in(0, 5'd1, 5'd2, 1, 1, 5'd9, 0, 0, 0, 1), C_NORM,  0, 0, S_RUN, 0);
    tbl[9] = mk_vec(mk_in(0, 5'd4, 5'd6, 0, 1, 5'd4, 1, 0, 0, 0), C_NORM,  0, 0, S_RUN, 0);
    for (int i = 0; i < 10; i++) apply(tbl[i], 10 + i);

    // memory wait with a redirect held in EX, ack on the fourth cycle
    wait_in.redir = 1'b1;
    ack_in = wait_in;
    ack_in.ack = 1'b1;
    apply(mk_vec(wait_in, C_FRZ,   1, 0, S_MW,  0), 30);
    apply(mk_vec(wait_in, C_FRZ,   1, 0, S_MW,  0), 31);
    apply(mk_vec(wait_in, C_FRZ,   1, 0, S_MW,  0), 32);
    apply(mk_vec(ack_in,  C_REDIR, 0, 1, S_RUN, 0), 33);
    apply(mk_vec(idle,    C_NORM,  0, 0, S_RUN, 0), 34);

    // release cycle with a load-use hazard pending
    lu_in = mk_in(0, 5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 1, 0);
    apply(mk_vec(lu_in, C_FRZ, 1, 0, S_MW, 0), 40);
    lu_in.ack = 1'b1;
    apply(mk_vec(lu_in, C_LU, 1, 0, S_RUN, 0), 41);

    // timeout: four frozen cycles, then FAULT until reset
    wait_in.redir = 1'b0;
    apply(mk_vec(wait_in, C_FRZ, 1, 0, S_MW,  0), 50);
    apply(mk_vec(wait_in, C_FRZ, 1, 0, S_MW,  0), 51);
    apply(mk_vec(wait_in, C_FRZ, 1, 0, S_MW,  0), 52);
    apply(mk_vec(wait_in, C_FRZ, 1, 0, S_FLT, 1), 53);
    apply(mk_vec(ack_in,  C_FRZ, 0, 0, S_FLT, 1), 54);
    apply(mk_vec(idle,    C_FRZ, 0, 0, S_FLT, 1), 55);
    apply(mk_vec(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_RST, 0, 0, S_RUN, 0), 56);
    apply(mk_vec(idle, C_NORM, 0, 0, S_RUN, 0), 57);

    // saturation: 20 load-use stalls with randomised register numbers
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(1, 31);
      lu_in = mk_in(0, 5'(k), 5'($urandom_range(0, 31)), 1, $urandom_range(0, 1) == 1,
                    5'(k), 1, 0, 0, 0);
      apply(mk_vec(lu_in, C_LU, 1, 0, S_RUN, 0), 60 + i);
    end

    // reset asserted in the second MEM_WAIT cycle
    apply(mk_vec(wait_in, C_FRZ, 1, 0, S_MW, 0), 90);
    apply(mk_vec(wait_in, C_FRZ, 1, 0, S_MW, 0), 91);
    apply(mk_vec(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_RST, 0, 0, S_RUN, 0), 92);
    apply(mk_vec(idle, C_NORM, 0, 0, S_RUN, 0), 93);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core. Takes the decoded register usage of the ID-stage instruction, the load, branch and jump status of the EX stage, and the data-memory handshake of the MEM stage. From these it drives the PC and pipeline-register write enables and flushes. It owns the load-use stall, the taken-branch/jump redirect, a memory-wait freeze with watchdog, and saturating stall/flush event counters.

## Interface
- CNT_W, 16, width of each event counter
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before fault (1..2^CNT_W-1)
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high
- id_rs1_addr / id_rs2_addr  in  5  ID-stage source registers
- id_uses_rs1 / id_uses_rs2  in  1  ID instruction actually reads rs1/rs2 (from decode type)
- ex_rd_addr  in  5  EX-stage destination register
- ex_mem_read  in  1  EX instruction is a load (MemRead)
- ex_redirect  in  1  EX branch taken, or JAL/JALR in EX
- mem_req  in  1  MEM instruction is load/store
- mem_ack  in  1  data memory completes the MEM access this cycle
- pc_write, ifid_write, idex_write, exmem_write  out  1  register enables
- ifid_flush, idex_flush, memwb_bubble  out  1  insert NOP into register
- fault  out  1  sticky memory-timeout error
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- States: RUN, MEM_WAIT, FAULT. Encoding in the package.
- Load-use: load_use = ex_mem_read & (ex_rd_addr≠0) & ((id_uses_rs1 & rs1==rd) | (id_uses_rs2 & rs2==rd)).
- Memory stall: mem_stall = mem_req & ~mem_ack.
- RUN priority, highest first:
  - mem_stall: freeze — pc_write, ifid_write, idex_write, exmem_write = 0; memwb_bubble=1; no flush. Next state MEM_WAIT. stall_count+1.
  - ex_redirect: pc_write=1 (PC takes target); ifid_flush=1, idex_flush=1; others write. flush_count+1. Overrides load_use, since the ID instruction is wrong-path.
  - load_use: pc_write=0, ifid_write=0, idex_flush=1; exmem_write=1. stall_count+1.
  - else: all enables 1, flushes 0.
- MEM_WAIT:
  - Freeze as above while ~mem_ack. Wait counter increments; stall_count+1 per cycle.
  - On mem_ack: the RUN rules apply combinationally in that same cycle, with mem_stall treated as 0. Next state RUN, wait counter cleared.
  - If the wait counter reaches MEM_TIMEOUT with no ack: next state FAULT.
- FAULT: all enables 0, memwb_bubble=1, fault=1. Exit only via reset.
- Counters saturate at 2^CNT_W-1; they never wrap.
- An EX redirect seen during MEM_WAIT is held by the frozen EX/MEM state. It is acted on only in the release cycle.

## Timing
- All enable, flush and bubble outputs are combinational from state plus current inputs, effective at the same clock edge.
- fault, state and counters are registered, so each updates one edge after its cause.
- Load-use costs exactly one bubble. In the next cycle the load is in MEM and the hazard is clear.
- Redirect penalty is two flushed slots.
- Reset, held high: pc_write=0, ifid_write/idex_write/exmem_write=0, ifid_flush=1, idex_flush=1, memwb_bubble=1.
- After the reset edge: state RUN, wait counter 0, fault 0, stall_count 0, flush_count 0.
- Reset asserted mid-MEM_WAIT or in FAULT returns to RUN on the next edge. No ack is required.
- mem_ack asserted without mem_req is ignored.

## Structure
- Package hazard_pkg holds:
  - the state typedef (RUN/MEM_WAIT/FAULT);
  - the NOP encoding 32'h00000013 used by stage registers on flush;
  - the opcode constants shared with the decoder.
- One sub-module: sat_counter (parameter W; inputs inc, clr; output value). Instantiated twice for the event counters. The wait counter is internal.

## Test plan
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID -> pc_write=0, ifid_write=0, idex_flush=1 for one cycle; stall_count 0→1. Same case with rd=x0 -> no stall.
- Redirect plus load-use together: ex_redirect=1 and load_use=1 -> pc_write=1, ifid_flush=1, idex_flush=1; flush_count+1; stall_count unchanged.
- Memory wait: mem_req=1, ack after 3 cycles -> 3 frozen cycles with memwb_bubble=1; release on the ack cycle; stall_count=3; state returns to RUN.
- Timeout: MEM_TIMEOUT=4, no ack -> FAULT entered after 4 wait cycles, fault=1 and outputs frozen. Then reset=1 -> RUN, fault=0.
- Saturation: CNT_W=4, 20 consecutive load-use stalls -> stall_count holds 15.
- Reset mid-wait: reset asserted in cycle 2 of MEM_WAIT -> after the edge, state RUN and counters 0. During reset, ifid_flush=idex_flush=1.
